// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer: opcode and
// funct codes, FSM state encodings, ALU operation codes, datapath mux
// encodings and the bundle of control outputs driven each cycle.
package mc_ctrl_pkg;

    // Primary opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes that change the control sequence
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Sequencer states, 4-bit encoding shared with the datapath
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_RWB    = 4'd3,
        S_EXEC_I = 4'd4,
        S_IWB    = 4'd5,
        S_MEMADR = 4'd6,
        S_MEMRD  = 4'd7,
        S_MEMWB  = 4'd8,
        S_MEMWR  = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JR     = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    // ALU operation codes; ALUOP_RTYPE defers to aludec via funct
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_OR    = 3'b010;
    localparam logic [2:0] ALUOP_SLT   = 3'b011;
    localparam logic [2:0] ALUOP_AND   = 3'b100;
    localparam logic [2:0] ALUOP_RTYPE = 3'b111;

    // Register file destination select
    localparam logic [1:0] DEST_RD  = 2'b00;
    localparam logic [1:0] DEST_RT  = 2'b01;
    localparam logic [1:0] DEST_R31 = 2'b10;

    // Register file write-back source select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_PC     = 2'b10;
    localparam logic [1:0] RES_SHIFT  = 2'b11;

    // ALU A operand select
    localparam logic ALUA_PC = 1'b0;
    localparam logic ALUA_RS = 1'b1;

    // ALU B operand select
    localparam logic [1:0] ALUB_RT      = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    // Every control output except the sticky bus error flag
    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       iord;
        logic       mem_req;
        logic       mem_we;
        logic       reg_we;
        logic [1:0] dest_reg_c;
        logic [1:0] result_c;
        logic       alu_a_c;
        logic [1:0] alu_b_c;
        logic [2:0] aluop;
        logic       ext_c;
        logic       sh_d_c;
        logic [1:0] pc_src;
        logic       retire;
    } ctrl_t;

    // Where DECODE goes for a given instruction; S_FETCH marks an opcode
    // we do not implement, which is retired as a NOP.
    function automatic state_t decode_next(input logic [5:0] op_c,
                                           input logic [5:0] funct);
        state_t nxt;
        case (op_c)
            OP_RTYPE:                  nxt = (funct == FN_JR) ? S_JR : S_EXEC_R;
            OP_LW, OP_SW:              nxt = S_MEMADR;
            OP_BEQ, OP_BNE:            nxt = S_BRANCH;
            OP_J, OP_JAL:              nxt = S_JUMP;
            OP_ADDI, OP_LUI, OP_ORI,
            OP_SLTI, OP_ANDI:          nxt = S_EXEC_I;
            default:                   nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

    // ALU operation for the immediate-arithmetic group
    function automatic logic [2:0] imm_aluop(input logic [5:0] op_c);
        logic [2:0] op;
        case (op_c)
            OP_ORI:  op = ALUOP_OR;
            OP_SLTI: op = ALUOP_SLT;
            OP_ANDI: op = ALUOP_AND;
            default: op = ALUOP_ADD;
        endcase
        return op;
    endfunction

    // States that hold mem_req high and therefore run the timeout counter
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_mem_timer.sv
// Memory access watchdog. Counts consecutive cycles in which a request is
// outstanding without mem_ready and flags expiry on the MEM_TIMEOUT-th such
// cycle. A completing access, an idle cycle or reset returns it to zero, so
// every new access starts with a fresh budget.
module mc_mem_timer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ready,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST = TO_W'(MEM_TIMEOUT - 1);

    logic [TO_W-1:0] cnt;

    // Count waiting cycles of the current access, clear whenever it ends
    always_ff @(posedge clk) begin
        if (!rst_n || !active || ready) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TO_W'(1);
        end
    end

    // mem_ready on the last allowed cycle still completes normally
    assign expire = active && !ready && (cnt == LAST);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for the MIPS core. One ALU and one unified
// instruction/data memory are time-shared across the cycles of each
// instruction; memory accesses use a mem_req/mem_ready handshake so memory
// latency can vary. Control outputs are decoded from the current state, with
// the fetch handshake and branch decision folded in where needed. A memory
// access that never completes parks the sequencer in HALT with bus_err set
// until the next reset.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op_c,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       iord,
    output logic       mem_req,
    output logic       mem_we,
    output logic       reg_we,
    output logic [1:0] dest_reg_c,
    output logic [1:0] result_c,
    output logic       alu_a_c,
    output logic [1:0] alu_b_c,
    output logic [2:0] aluop,
    output logic       ext_c,
    output logic       sh_d_c,
    output logic [1:0] pc_src,
    output logic       retire,
    output logic       bus_err
);

    state_t state;
    logic   bus_err_q;
    logic   mem_active;
    logic   expire;
    ctrl_t  ctrl;

    assign mem_active = is_mem_state(state);

    mc_mem_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_mem_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .active (mem_active),
        .ready  (mem_ready),
        .expire (expire)
    );

    // Sequencer state and sticky bus error; a timeout overrides every transition
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            bus_err_q <= 1'b0;
        end else if (expire) begin
            state     <= S_HALT;
            bus_err_q <= 1'b1;
        end else begin
            case (state)
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: state <= decode_next(op_c, funct);
                S_EXEC_R: state <= S_RWB;
                S_RWB:    state <= S_FETCH;
                S_EXEC_I: state <= S_IWB;
                S_IWB:    state <= S_FETCH;
                S_MEMADR: state <= (op_c == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWB:  state <= S_FETCH;
                S_MEMWR:  if (mem_ready) state <= S_FETCH;
                S_BRANCH: state <= S_FETCH;
                S_JUMP:   state <= S_FETCH;
                S_JR:     state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Per-state control decode; everything is silenced while reset is held so
    // an aborted instruction cannot write anything in the reset cycle
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b0;
                ctrl.alu_a_c = ALUA_PC;
                ctrl.alu_b_c = ALUB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pc_src  = PCSRC_ALU;
                ctrl.ir_we   = mem_ready;
                ctrl.pc_we   = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_a_c = ALUA_PC;
                ctrl.alu_b_c = ALUB_IMM_SH2;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.retire  = (decode_next(op_c, funct) == S_FETCH);
            end
            S_EXEC_R: begin
                ctrl.alu_a_c = ALUA_RS;
                ctrl.alu_b_c = ALUB_RT;
                ctrl.aluop   = ALUOP_RTYPE;
                ctrl.sh_d_c  = (funct == FN_SLL);
            end
            S_RWB: begin
                ctrl.reg_we     = 1'b1;
                ctrl.dest_reg_c = DEST_RD;
                ctrl.result_c   = ((funct == FN_SLL) || (funct == FN_SRL)) ? RES_SHIFT : RES_ALUOUT;
                ctrl.retire     = 1'b1;
            end
            S_EXEC_I: begin
                ctrl.alu_a_c = ALUA_RS;
                ctrl.alu_b_c = ALUB_IMM;
                ctrl.ext_c   = (op_c == OP_LUI);
                ctrl.aluop   = imm_aluop(op_c);
            end
            S_IWB: begin
                ctrl.reg_we     = 1'b1;
                ctrl.dest_reg_c = DEST_RT;
                ctrl.result_c   = RES_ALUOUT;
                ctrl.retire     = 1'b1;
            end
            S_MEMADR: begin
                ctrl.alu_a_c = ALUA_RS;
                ctrl.alu_b_c = ALUB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_we     = 1'b1;
                ctrl.dest_reg_c = DEST_RT;
                ctrl.result_c   = RES_MDR;
                ctrl.retire     = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.iord    = 1'b1;
                ctrl.retire  = mem_ready;
            end
            S_BRANCH: begin
                ctrl.alu_a_c = ALUA_RS;
                ctrl.alu_b_c = ALUB_RT;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pc_src  = PCSRC_ALUOUT;
                ctrl.pc_we   = ((op_c == OP_BEQ) && zero) || ((op_c == OP_BNE) && !zero);
                ctrl.retire  = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src = PCSRC_JUMP;
                ctrl.pc_we  = 1'b1;
                ctrl.retire = 1'b1;
                if (op_c == OP_JAL) begin
                    ctrl.reg_we     = 1'b1;
                    ctrl.dest_reg_c = DEST_R31;
                    ctrl.result_c   = RES_PC;
                end
            end
            S_JR: begin
                ctrl.pc_src = PCSRC_RS;
                ctrl.pc_we  = 1'b1;
                ctrl.retire = 1'b1;
            end
            default: ctrl = '0;
        endcase
        if (!rst_n) begin
            ctrl = '0;
        end
    end

    assign pc_we      = ctrl.pc_we;
    assign ir_we      = ctrl.ir_we;
    assign iord       = ctrl.iord;
    assign mem_req    = ctrl.mem_req;
    assign mem_we     = ctrl.mem_we;
    assign reg_we     = ctrl.reg_we;
    assign dest_reg_c = ctrl.dest_reg_c;
    assign result_c   = ctrl.result_c;
    assign alu_a_c    = ctrl.alu_a_c;
    assign alu_b_c    = ctrl.alu_b_c;
    assign aluop      = ctrl.aluop;
    assign ext_c      = ctrl.ext_c;
    assign sh_d_c     = ctrl.sh_d_c;
    assign pc_src     = ctrl.pc_src;
    assign retire     = ctrl.retire;
    assign bus_err    = bus_err_q && rst_n;

endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl. A reference model expands each instruction into the
// cycle-by-cycle list of control words it should produce, together with the
// mem_ready value to drive in that cycle; the bench replays the list and
// compares every output every cycle.
module tb_mc_ctrl;

    localparam int TMO = 4;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_JAL   = 6'b000011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_BNE   = 6'b000101;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_SLTI  = 6'b001010;
    localparam logic [5:0] T_ANDI  = 6'b001100;
    localparam logic [5:0] T_ORI   = 6'b001101;
    localparam logic [5:0] T_LUI   = 6'b001111;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BAD   = 6'b111111;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_OR    = 6'b100101;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       iord;
        logic       mem_req;
        logic       mem_we;
        logic       reg_we;
        logic [1:0] dest_reg_c;
        logic [1:0] result_c;
        logic       alu_a_c;
        logic [1:0] alu_b_c;
        logic [2:0] aluop;
        logic       ext_c;
        logic       sh_d_c;
        logic [1:0] pc_src;
        logic       retire;
        logic       bus_err;
    } exp_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        exp_t       e;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op_c;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_we, ir_we, iord, mem_req, mem_we, reg_we;
    logic [1:0] dest_reg_c, result_c, alu_b_c, pc_src;
    logic       alu_a_c, ext_c, sh_d_c, retire, bus_err;
    logic [2:0] aluop;

    step_t plan[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.MEM_TIMEOUT(TMO), .TO_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_c       (op_c),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .iord       (iord),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .reg_we     (reg_we),
        .dest_reg_c (dest_reg_c),
        .result_c   (result_c),
        .alu_a_c    (alu_a_c),
        .alu_b_c    (alu_b_c),
        .aluop      (aluop),
        .ext_c      (ext_c),
        .sh_d_c     (sh_d_c),
        .pc_src     (pc_src),
        .retire     (retire),
        .bus_err    (bus_err)
    );

    function automatic logic known_op(input logic [5:0] op);
        case (op)
            T_RTYPE, T_J, T_JAL, T_BEQ, T_BNE, T_ADDI, T_SLTI,
            T_ANDI, T_ORI, T_LUI, T_LW, T_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic noise();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input logic rdy, input exp_t e);
        step_t s;
        s.op = op; s.fn = fn; s.z = z; s.rdy = rdy; s.e = e;
        plan.push_back(s);
    endtask

    // Expected control words of one instruction, from fetch to retirement
    task automatic add_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fwait, input int mwait, input logic z);
        exp_t e;
        for (int i = 0; i <= fwait; i++) begin
            e = '0; e.mem_req = 1'b1; e.alu_b_c = 2'b01;
            e.ir_we = (i == fwait); e.pc_we = (i == fwait);
            push(op, fn, z, (i == fwait), e);
        end
        e = '0; e.alu_b_c = 2'b11;
        e.retire = !known_op(op);
        push(op, fn, z, noise(), e);
        if (!known_op(op)) return;
        e = '0;
        case (op)
            T_RTYPE: begin
                if (fn == F_JR) begin
                    e.pc_src = 2'b11; e.pc_we = 1'b1; e.retire = 1'b1;
                    push(op, fn, z, noise(), e);
                end else begin
                    e.alu_a_c = 1'b1; e.aluop = 3'b111; e.sh_d_c = (fn == F_SLL);
                    push(op, fn, z, noise(), e);
                    e = '0; e.reg_we = 1'b1; e.retire = 1'b1;
                    e.result_c = (fn == F_SLL || fn == F_SRL) ? 2'b11 : 2'b00;
                    push(op, fn, z, noise(), e);
                end
            end
            T_LW, T_SW: begin
                e.alu_a_c = 1'b1; e.alu_b_c = 2'b10;
                push(op, fn, z, noise(), e);
                for (int i = 0; i <= mwait; i++) begin
                    e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = (op == T_SW);
                    e.retire = (op == T_SW) && (i == mwait);
                    push(op, fn, z, (i == mwait), e);
                end
                if (op == T_LW) begin
                    e = '0; e.reg_we = 1'b1; e.dest_reg_c = 2'b01; e.result_c = 2'b01;
                    e.retire = 1'b1;
                    push(op, fn, z, noise(), e);
                end
            end
            T_BEQ, T_BNE: begin
                e.alu_a_c = 1'b1; e.aluop = 3'b001; e.pc_src = 2'b01; e.retire = 1'b1;
                e.pc_we = (op == T_BEQ) ? z : !z;
                push(op, fn, z, noise(), e);
            end
            T_J, T_JAL: begin
                e.pc_src = 2'b10; e.pc_we = 1'b1; e.retire = 1'b1;
                if (op == T_JAL) begin
                    e.reg_we = 1'b1; e.dest_reg_c = 2'b10; e.result_c = 2'b10;
                end
                push(op, fn, z, noise(), e);
            end
            default: begin
                e.alu_a_c = 1'b1; e.alu_b_c = 2'b10; e.ext_c = (op == T_LUI);
                e.aluop = (op == T_ORI) ? 3'b010 : (op == T_SLTI) ? 3'b011 :
                          (op == T_ANDI) ? 3'b100 : 3'b000;
                push(op, fn, z, noise(), e);
                e = '0; e.reg_we = 1'b1; e.dest_reg_c = 2'b01; e.retire = 1'b1;
                push(op, fn, z, noise(), e);
            end
        endcase
    endtask

    task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic rdy);
        @(negedge clk);
        rst_n = rst; op_c = op; funct = fn; zero = z; mem_ready = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input exp_t want);
        exp_t got;
        got = {pc_we, ir_we, iord, mem_req, mem_we, reg_we, dest_reg_c, result_c,
               alu_a_c, alu_b_c, aluop, ext_c, sh_d_c, pc_src, retire, bus_err};
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, got, want);
        end
    endtask

    task automatic run_plan(input string tag);
        foreach (plan[i]) begin
            applyStimulus(1'b1, plan[i].op, plan[i].fn, plan[i].z, plan[i].rdy);
            checkOutput($sformatf("%s cyc%0d", tag, i + 1), plan[i].e);
        end
        plan.delete();
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, T_BAD, 6'd0, 1'b0, noise());
            checkOutput($sformatf("reset cyc%0d", i + 1), '0);
        end
    endtask

    task automatic truncate(input int keep);
        while (plan.size() > keep) plan.pop_back();
    endtask

    initial begin
        logic [5:0] ops [13];
        logic [5:0] fns [6];
        exp_t       halt_e;
        logic [5:0] op, fn;

        ops = '{T_RTYPE, T_J, T_JAL, T_BEQ, T_BNE, T_ADDI, T_SLTI,
                T_ANDI, T_ORI, T_LUI, T_LW, T_SW, T_BAD};
        fns = '{F_SLL, F_SRL, F_JR, F_ADD, F_SUB, F_OR};

        do_reset(2);

        add_instr(T_ADDI, 6'd0, 0, 0, 1'b0);  run_plan("addi");
        add_instr(T_LW, 6'd0, 2, 3, 1'b0);    run_plan("lw_waits");
        add_instr(T_BEQ, 6'd0, 0, 0, 1'b1);   run_plan("beq_taken");
        add_instr(T_BEQ, 6'd0, 0, 0, 1'b0);   run_plan("beq_not");
        add_instr(T_BNE, 6'd0, 0, 0, 1'b1);   run_plan("bne_not");
        add_instr(T_BNE, 6'd0, 0, 0, 1'b0);   run_plan("bne_taken");
        add_instr(T_JAL, 6'd0, 0, 0, 1'b0);   run_plan("jal");
        add_instr(T_RTYPE, F_JR, 0, 0, 1'b0); run_plan("jr");
        add_instr(T_RTYPE, F_SLL, 0, 0, 1'b0); run_plan("sll");
        add_instr(T_LUI, 6'd0, 1, 0, 1'b0);   run_plan("lui");

        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 12)];
            fn = fns[$urandom_range(0, 5)];
            add_instr(op, fn, $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1), noise());
            run_plan($sformatf("rnd%0d_op%02h", n, op));
        end

        add_instr(T_SW, 6'd0, 0, TMO + 4, 1'b0);
        truncate(3 + TMO);
        halt_e = '0; halt_e.bus_err = 1'b1;
        for (int i = 0; i < 3; i++) push(T_SW, 6'd0, 1'b0, noise(), halt_e);
        run_plan("sw_timeout");

        do_reset(1);
        add_instr(T_SW, 6'd0, TMO - 1, TMO - 1, 1'b0); run_plan("sw_last_cycle_ready");

        add_instr(T_LW, 6'd0, 0, 5, 1'b0);
        truncate(5);
        run_plan("lw_abort");
        do_reset(2);
        add_instr(T_BAD, 6'd0, 0, 0, 1'b0);   run_plan("unknown_op");
        add_instr(T_ORI, 6'd0, 0, 0, 1'b0);   run_plan("ori_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
